medfreq: RTL and testbench

MEDFREQ -- requirements
Module: medfreq

---
 rtl/medfreq.sv | 99 +++++++++
 tb/tb_medfreq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/medfreq.sv
// Period meter for a slow square wave: synchronises senal, strobes each rising edge,
// reports the reloj-cycle distance between consecutive edges and flags loss of signal.
module medfreq #(
    parameter int ANCHO  = 24,
    parameter int LIMITE = 250000
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             senal,
    output logic             pulso,
    output logic [ANCHO-1:0] periodo,
    output logic             valido,
    output logic             sin_senal
);

    typedef enum logic [1:0] {ESPERA, MIDIENDO, PERDIDA} estado_t;

    localparam logic [ANCHO-1:0] LIM    = ANCHO'(LIMITE);
    localparam logic [ANCHO-1:0] LIM_M1 = ANCHO'(LIMITE - 1);

    estado_t          estado_q, estado_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             pulso_q, pulso_d, valido_q, valido_d, sin_q, sin_d;
    logic [ANCHO-1:0] periodo_q, periodo_d, cuenta_q, cuenta_d;
    logic             flanco;

    always_comb begin
        s1_d      = senal;
        s2_d      = s1_q;
        s3_d      = s2_q;
        flanco    = s2_q & ~s3_q;
        pulso_d   = flanco;
        valido_d  = 1'b0;
        estado_d  = estado_q;
        cuenta_d  = cuenta_q;
        periodo_d = periodo_q;
        sin_d     = sin_q;
        case (estado_q)
            ESPERA: begin
                if (flanco) begin
                    estado_d = MIDIENDO;
                    cuenta_d = '0;
                end
            end
            MIDIENDO: begin
                // cuenta holds P-1 when the next edge lands P cycles after the last one
                if (flanco) begin
                    periodo_d = cuenta_q + ANCHO'(1);
                    valido_d  = 1'b1;
                    cuenta_d  = '0;
                end else if (cuenta_q == LIM_M1) begin
                    estado_d = PERDIDA;
                    cuenta_d = LIM;
                    sin_d    = 1'b1;
                end else begin
                    cuenta_d = cuenta_q + ANCHO'(1);
                end
            end
            PERDIDA: begin
                if (flanco) begin
                    estado_d = MIDIENDO;
                    cuenta_d = '0;
                    sin_d    = 1'b0;
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado_q  <= ESPERA;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            pulso_q   <= 1'b0;
            valido_q  <= 1'b0;
            sin_q     <= 1'b0;
            periodo_q <= '0;
            cuenta_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            pulso_q   <= pulso_d;
            valido_q  <= valido_d;
            sin_q     <= sin_d;
            periodo_q <= periodo_d;
            cuenta_q  <= cuenta_d;
        end
    end

    assign pulso     = pulso_q;
    assign valido    = valido_q;
    assign sin_senal = sin_q;
    assign periodo   = periodo_q;

endmodule

// File: tb/tb_medfreq.sv
// Directed bench for medfreq with LIMITE=20: period measurement, loss of signal,
// recovery, the edge-at-limit rule, asynchronous reset and synchroniser glitches.
module tb_medfreq;

    logic        reloj = 1'b0;
    logic        reset = 1'b1;
    logic        senal = 1'b0;
    logic        pulso, valido, sin_senal;
    logic [15:0] periodo;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int viol   = 0;
    logic sin_prev = 1'b0;
    int pcyc[$];
    int vcyc[$];
    int vper[$];
    int srise[$];
    int sfall[$];

    medfreq #(.ANCHO(16), .LIMITE(20)) dut (
        .reloj    (reloj),
        .reset    (reset),
        .senal    (senal),
        .pulso    (pulso),
        .periodo  (periodo),
        .valido   (valido),
        .sin_senal(sin_senal)
    );

    always #5 reloj = ~reloj;

    always @(posedge reloj) cyc = cyc + 1;

    always @(negedge reloj) begin
        if (!reset) begin
            if (pulso) pcyc.push_back(cyc);
            if (valido) begin
                vcyc.push_back(cyc);
                vper.push_back(int'(periodo));
                if (!pulso) viol = viol + 1;
            end
            if (sin_senal && !sin_prev) srise.push_back(cyc);
            if (!sin_senal && sin_prev) sfall.push_back(cyc);
        end
        sin_prev = sin_senal;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge reloj);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int p0, v0, r0, f0;

        // reset state
        #2;
        chk("rst_pulso", int'(pulso), 0);
        chk("rst_valido", int'(valido), 0);
        chk("rst_sin", int'(sin_senal), 0);
        chk("rst_periodo", int'(periodo), 0);
        step(2);
        reset = 1'b0;

        // square wave, period 8
        p0 = pcyc.size(); v0 = vcyc.size();
        for (int i = 0; i < 5; i++) begin
            senal = 1'b1; step(4);
            senal = 1'b0; step(4);
        end
        chk("sq_pulsos", pcyc.size() - p0, 5);
        chk("sq_valids", vcyc.size() - v0, 4);
        for (int i = 1; i < 5; i++) begin
            chk("sq_gap", pcyc[p0 + i] - pcyc[p0 + i - 1], 8);
            chk("sq_periodo", vper[v0 + i - 1], 8);
            chk("sq_vld_with_pulso", vcyc[v0 + i - 1], pcyc[p0 + i]);
        end
        chk("sq_sin", int'(sin_senal), 0);

        // held low -> loss 20 cycles after the last pulso, periodo kept
        r0 = srise.size();
        step(30);
        chk("loss_sin", int'(sin_senal), 1);
        chk("loss_rises", srise.size() - r0, 1);
        chk("loss_delay", srise[r0] - pcyc[pcyc.size() - 1], 20);
        chk("loss_periodo", int'(periodo), 8);
        chk("loss_no_valid", vcyc.size() - v0, 4);

        // recovery from loss with edges 10 apart
        p0 = pcyc.size(); v0 = vcyc.size(); f0 = sfall.size();
        senal = 1'b1; step(5);
        senal = 1'b0; step(5);
        senal = 1'b1; step(5);
        senal = 1'b0; step(5);
        chk("rec_pulsos", pcyc.size() - p0, 2);
        chk("rec_sin_clear_cyc", sfall[f0], pcyc[p0]);
        chk("rec_valids", vcyc.size() - v0, 1);
        chk("rec_periodo", vper[v0], 10);
        chk("rec_vld_cyc", vcyc[v0], pcyc[p0 + 1]);

        // edges exactly LIMITE apart: edge wins over loss
        r0 = srise.size(); v0 = vcyc.size();
        step(10);
        for (int i = 0; i < 2; i++) begin
            senal = 1'b1; step(10);
            senal = 1'b0; step(10);
        end
        chk("lim_valids", vcyc.size() - v0, 2);
        chk("lim_periodo0", vper[v0], 20);
        chk("lim_periodo1", vper[v0 + 1], 20);
        chk("lim_no_loss", srise.size() - r0, 0);
        chk("lim_sin", int'(sin_senal), 0);

        // asynchronous reset shortly after an edge; senal stays high across release
        senal = 1'b1; step(5);
        chk("pre_rst_periodo", int'(periodo), 20);
        reset = 1'b1;
        #2;
        chk("arst_periodo", int'(periodo), 0);
        chk("arst_pulso", int'(pulso), 0);
        chk("arst_valido", int'(valido), 0);
        chk("arst_sin", int'(sin_senal), 0);
        step(2);
        p0 = pcyc.size(); v0 = vcyc.size();
        reset = 1'b0;
        step(4);
        senal = 1'b0; step(4);
        senal = 1'b1; step(12);
        senal = 1'b0; step(4);
        chk("arst_pulsos", pcyc.size() - p0, 2);
        chk("arst_gap", pcyc[p0 + 1] - pcyc[p0], 8);
        chk("arst_valids", vcyc.size() - v0, 1);
        chk("arst_periodo_new", vper[v0], 8);
        chk("arst_vld_cyc", vcyc[v0], pcyc[p0 + 1]);

        // glitches: one between clock edges, one held across exactly one edge
        p0 = pcyc.size();
        senal = 1'b1; #3;
        senal = 1'b0; step(6);
        chk("glitch_unsampled", pcyc.size() - p0, 0);
        senal = 1'b1; step(1);
        senal = 1'b0; step(6);
        chk("glitch_sampled", pcyc.size() - p0, 1);

        chk("valid_without_pulso", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
